// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: hold levels, bus widths,
// the NOP encoding, FSM state encodings and the buffered-instruction record.
package ifu_fetch_pkg;

    localparam int HOLD_FLAG_BUS = 3;
    localparam int MEM_ADDR_BUS  = 32;
    localparam int INST_BUS      = 32;

    localparam logic [HOLD_FLAG_BUS-1:0] HOLD_NONE = 3'd0;
    localparam logic [HOLD_FLAG_BUS-1:0] HOLD_PC   = 3'd1;
    localparam logic [HOLD_FLAG_BUS-1:0] HOLD_IF   = 3'd2;
    localparam logic [HOLD_FLAG_BUS-1:0] HOLD_ID   = 3'd3;

    localparam logic [INST_BUS-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [MEM_ADDR_BUS-1:0] addr;
        logic [INST_BUS-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction bus: request/grant address phase, in-order rvalid data phase.
// master = fetch unit, slave = memory side.
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic                    req;
    logic [MEM_ADDR_BUS-1:0] addr;
    logic                    gnt;
    logic                    rvalid;
    logic [INST_BUS-1:0]     rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/ifu_fetch_fifo.sv
// Synchronous FIFO of {pc, instruction} records with push/pop/flush and an occupancy count.
// Flush wins over push and pop; DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t data_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: turns controller jump/hold into bus requests and buffers responses.
// Optional IFU_BYPASS_EN forwards a response straight to inst_o when the buffer is empty.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [MEM_ADDR_BUS-1:0] RESET_ADDR      = 32'h0000_0000,
    parameter int                      FIFO_DEPTH      = 2,
    parameter int                      MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     jump_flag_i,
    input  logic [MEM_ADDR_BUS-1:0]  jump_addr_i,
    input  logic [HOLD_FLAG_BUS-1:0] hold_flag_i,
    ifu_fetch_if.master              ibus,
    output logic                     inst_valid_o,
    output logic [INST_BUS-1:0]      inst_o,
    output logic [MEM_ADDR_BUS-1:0]  inst_addr_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e              state_q;
    logic [MEM_ADDR_BUS-1:0] pc_q;
    logic [MEM_ADDR_BUS-1:0] rsp_pc_q;
    logic [OW-1:0]           outst_q, outst_d;
    logic [OW-1:0]           discard_q, discard_d;
    logic                    req_pend_q;

    logic                    issue_ok, req, acc, rsp_ok, byp, push, pop;
    logic [31:0]             occ;
    logic [MEM_ADDR_BUS-1:0] jump_pc;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    fetch_entry_t            fifo_head, push_entry;

    assign jump_pc = jump_addr_i & ~32'h3;
    assign occ     = 32'(outst_q) + 32'(fifo_count);

    assign issue_ok = (state_q != ST_BOOT) && (hold_flag_i < HOLD_PC)
                   && (outst_q < OW'(MAX_OUTSTANDING)) && (occ < 32'(FIFO_DEPTH));
    // An ungranted request stays up through a hold; only a jump may withdraw it.
    assign req    = !jump_flag_i && (req_pend_q || issue_ok);
    assign acc    = req && ibus.gnt;
    assign rsp_ok = ibus.rvalid && !jump_flag_i && (discard_q == '0);

`ifdef IFU_BYPASS_EN
    assign byp = rsp_ok && fifo_empty && (hold_flag_i < HOLD_IF);
`else
    assign byp = 1'b0;
`endif

    assign push       = rsp_ok && !byp;
    assign pop        = !fifo_empty && (hold_flag_i < HOLD_IF) && !jump_flag_i;
    assign push_entry = '{addr: rsp_pc_q, inst: ibus.rdata};

    assign ibus.req  = req;
    assign ibus.addr = pc_q;

    // Everything in flight at a jump belongs to the old stream.
    assign outst_d = outst_q + OW'(acc) - OW'(ibus.rvalid);

    always_comb begin
        discard_d = discard_q;
        if (jump_flag_i)
            discard_d = outst_d;
        else if (ibus.rvalid && (discard_q != '0))
            discard_d = discard_q - OW'(1);
    end

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = INST_NOP;
        inst_addr_o  = rsp_pc_q;
        if (!fifo_empty) begin
            inst_valid_o = 1'b1;
            inst_o       = fifo_head.inst;
            inst_addr_o  = fifo_head.addr;
        end else if (byp) begin
            inst_valid_o = 1'b1;
            inst_o       = ibus.rdata;
            inst_addr_o  = rsp_pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_ADDR;
            rsp_pc_q   <= RESET_ADDR;
            outst_q    <= '0;
            discard_q  <= '0;
            req_pend_q <= 1'b0;
        end else begin
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            req_pend_q <= req && !ibus.gnt;
            if (jump_flag_i) begin
                pc_q     <= jump_pc;
                rsp_pc_q <= jump_pc;
            end else begin
                if (acc)    pc_q     <= pc_q + 32'd4;
                if (rsp_ok) rsp_pc_q <= rsp_pc_q + 32'd4;
            end
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                default: state_q <= (discard_d != '0) ? ST_FLUSH : ST_RUN;
            endcase
        end
    end

    ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (jump_flag_i),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
